// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master controller.
// The frame carries the mode bit, the op code, then the data byte, MSB first.
package spi_master_pkg;

  localparam int FRAME_W   = 11;
  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    OP_WR_ADDR,
    OP_WR_DATA,
    OP_RD_ADDR,
    OP_RD_DATA
  } spi_op_e;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    RECV,
    GAP
  } state_e;

  // The slave's write/read mode bit is the op code's MSB.
  function automatic logic [FRAME_W-1:0] build_frame(input spi_op_e op,
                                                     input logic [DATA_W-1:0] data);
    return {op[1], op, data};
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Generic parallel-load register that shifts left (MSB out, LSB in).
// Used for both the outgoing frame and the incoming read byte.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         shift_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: one bit per clk, registered SS_n/MOSI, read byte capture.
// Define SPI_MASTER_SEQ_CHECK_EN to flag rd-addr/rd-data ordering errors on err.
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              err,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int DLY_W = 8;

  state_e                 state_reg, state_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [DLY_W-1:0]       dly_cnt_reg, dly_cnt_next;
  spi_op_e                op_reg;
  spi_op_e                cmd_op_e;
  logic                   accept;

  logic                   ss_n_reg, ss_n_next;
  logic                   cmd_ready_reg, cmd_ready_next;
  logic                   busy_reg, busy_next;
  logic                   rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]      rsp_data_reg;
  logic                   tx_load, tx_shift, rx_shift;
  logic [FRAME_W-1:0]     tx_q;
  logic [DATA_W-2:0]      rx_q;

  assign cmd_op_e = spi_op_e'(cmd_op);
  assign accept   = cmd_valid && cmd_ready_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      dly_cnt_reg <= '0;
      op_reg      <= OP_WR_ADDR;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      dly_cnt_reg <= dly_cnt_next;
      if (accept) begin
        op_reg <= cmd_op_e;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    dly_cnt_next = dly_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = SHIFT;
          bit_cnt_next = BIT_CNT_W'(FRAME_W - 1);
        end
      end
      SHIFT: begin
        if (bit_cnt_reg == '0) begin
          if (op_reg == OP_RD_DATA) begin
            if (RD_LAT > 0) begin
              state_next   = WAIT;
              dly_cnt_next = DLY_W'(RD_LAT - 1);
            end else begin
              state_next   = RECV;
              bit_cnt_next = BIT_CNT_W'(DATA_W - 1);
            end
          end else begin
            state_next   = spi_master_pkg::GAP;
            dly_cnt_next = DLY_W'(GAP - 1);
          end
        end else begin
          bit_cnt_next = bit_cnt_reg - 1'b1;
        end
      end
      WAIT: begin
        if (dly_cnt_reg == '0) begin
          state_next   = RECV;
          bit_cnt_next = BIT_CNT_W'(DATA_W - 1);
        end else begin
          dly_cnt_next = dly_cnt_reg - 1'b1;
        end
      end
      RECV: begin
        if (bit_cnt_reg == '0) begin
          state_next   = spi_master_pkg::GAP;
          dly_cnt_next = DLY_W'(GAP - 1);
        end else begin
          bit_cnt_next = bit_cnt_reg - 1'b1;
        end
      end
      spi_master_pkg::GAP: begin
        if (dly_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          dly_cnt_next = dly_cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so that the registered pins
  // line up with the state the FSM is entering.
  always_comb begin
    ss_n_next      = !(state_next inside {SHIFT, WAIT, RECV});
    cmd_ready_next = (state_next == IDLE);
    busy_next      = (state_next != IDLE);
    rsp_valid_next = (state_reg == RECV) && (bit_cnt_reg == '0);
    tx_load        = accept;
    tx_shift       = (state_reg == SHIFT);
    rx_shift       = (state_reg == RECV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_n_reg      <= 1'b1;
      cmd_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      ss_n_reg      <= ss_n_next;
      cmd_ready_reg <= cmd_ready_next;
      busy_reg      <= busy_next;
      rsp_valid_reg <= rsp_valid_next;
      if (rsp_valid_next) begin
        rsp_data_reg <= {rx_q, MISO};
      end
    end
  end

  // The frame drains to zeros, so MOSI idles low once the last bit is out.
  spi_shift_reg #(.W(FRAME_W)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data (build_frame(cmd_op_e, cmd_data)),
    .shift     (tx_shift),
    .shift_in  (1'b0),
    .q         (tx_q)
  );

  // Holds the first seven bits; the eighth goes straight into rsp_data.
  spi_shift_reg #(.W(DATA_W - 1)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift     (rx_shift),
    .shift_in  (MISO),
    .q         (rx_q)
  );

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic rd_addr_seen_reg;
  logic err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_seen_reg <= 1'b0;
      err_reg          <= 1'b0;
    end else if (accept) begin
      if (cmd_op_e == OP_RD_ADDR) begin
        if (rd_addr_seen_reg) begin
          err_reg <= 1'b1;
        end
        rd_addr_seen_reg <= 1'b1;
      end else if (cmd_op_e == OP_RD_DATA) begin
        if (!rd_addr_seen_reg) begin
          err_reg <= 1'b1;
        end
        rd_addr_seen_reg <= 1'b0;
      end
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign SS_n      = ss_n_reg;
  assign MOSI      = tx_q[FRAME_W-1];
  assign cmd_ready = cmd_ready_reg;
  assign busy      = busy_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;

endmodule
